// File: rtl/reg_file_output.sv
// reg_file_output: parallel-to-serial unloader. Captures a flattened vector
// of N_REG signed words and streams it out two words per beat over a
// valid/ready interface, in the same word order the 2-per-cycle shift-in
// register file expects.
module reg_file_output #(
  parameter int WIDTH = 32,
  parameter int N_REG = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*N_REG-1:0]  all_inputs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_1,
  output logic signed [WIDTH-1:0] out_2,
  output logic                    out_2_valid,
  output logic                    out_last,
  output logic                    done
);

  localparam int BEATS = (N_REG + 1) / 2;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam bit N_ODD = (N_REG % 2) == 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  // Word n lives at bits [(n+1)*WIDTH-1 : n*WIDTH]; shifting right by two
  // words moves reg_f[i+2] into reg_f[i] and zero-fills the top two slots.
  logic [WIDTH*N_REG-1:0]   reg_f_q, reg_f_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     beat_acc;
  logic                     load;

  // Stream outputs and the upstream handshake, all decoded from state/cnt.
  // The out_ready -> in_ready path is combinational so a new vector can be
  // taken on the final beat with no bubble.
  always_comb begin
    out_valid   = (state_q == SEND);
    out_last    = out_valid && (cnt_q == LAST_CNT);
    in_ready    = (state_q == IDLE) || (out_last && out_ready);
    out_1       = signed'(reg_f_q[WIDTH-1:0]);
    out_2       = (N_ODD && out_last) ? '0 : signed'(reg_f_q[2*WIDTH-1:WIDTH]);
    out_2_valid = out_valid && !(out_last && N_ODD);
    done        = done_q;
    beat_acc    = out_valid && out_ready;
    load        = in_valid && in_ready;
  end

  // Next-state: load in IDLE, shift per accepted beat in SEND, reload or
  // return to IDLE on the final beat.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    state_d = state_q;
    reg_f_d = reg_f_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          reg_f_d = all_inputs;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_acc) begin
          if (out_last) begin
            done_d = 1'b1;
            if (load) begin
              reg_f_d = all_inputs;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            reg_f_d = reg_f_q >> (2 * WIDTH);
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, data and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the data register is reset too, so out_1/out_2 read zero
      // after reset and a half-sent vector is never exposed again.
      reg_f_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of the others regardless of statement order.
      state_q <= state_d;
      reg_f_q <= reg_f_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule
